// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: data width, register index width and the
// MEM/WB control-bit encoding used by both the MEM/WB register and write-back.
package pipe_pkg;

    localparam int XLEN          = 32;
    localparam int REG_IDX_W     = 5;

    // Bit positions inside the 2-bit MEM/WB control field.
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_MEMTOREG = 0;

    typedef logic [XLEN-1:0]      word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bus: write-back fields in, decode read ports and
// write-back observation signals out.
interface wb_regfile_if;
    import pipe_pkg::*;

    word_t       alu_out_MEM_WB;
    word_t       data_out_MEM_WB;
    reg_idx_t    Write_Reg_MEM_WB;
    logic [1:0]  control_MEM_WB;
    reg_idx_t    rs1_addr;
    reg_idx_t    rs2_addr;
    word_t       rs1_data;
    word_t       rs2_data;
    word_t       wb_data;
    logic        wb_en;
    logic [31:0] wb_count;

    // Pipeline / decode side: drives the MEM/WB fields and read addresses.
    modport master (
        output alu_out_MEM_WB, data_out_MEM_WB, Write_Reg_MEM_WB, control_MEM_WB,
        output rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_data, wb_en, wb_count
    );

    // Register-file side.
    modport slave (
        input  alu_out_MEM_WB, data_out_MEM_WB, Write_Reg_MEM_WB, control_MEM_WB,
        input  rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_data, wb_en, wb_count
    );

endinterface

// File: rtl/wb_regfile_reg_array_2r1w.sv
// NREG x XLEN storage: asynchronous clear, one synchronous write port and two
// asynchronous read ports. x0 masking and bypass are handled by the caller.
module reg_array_2r1w
    import pipe_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     wr_en,
    input  reg_idx_t wr_addr,
    input  word_t    wr_data,
    input  reg_idx_t rd1_addr,
    input  reg_idx_t rd2_addr,
    output word_t    rd1_data,
    output word_t    rd2_data
);

    word_t mem [NREG];

    // Clear every entry on reset, otherwise commit the single write port.
    // NOTE: the whole array is reset because architectural registers must read
    // 0 right after reset; this rules out a RAM macro but the array is small.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            // NOTE: non-blocking so every reader in this edge sees the old value.
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd1_data = mem[rd1_addr];
    assign rd2_data = mem[rd2_addr];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus architectural register file: selects the write-back
// value, commits it, serves two bypassed read ports and counts commits.
module wb_regfile
    import pipe_pkg::*;
#(
    parameter int NREG   = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);

    word_t       wb_sel;
    logic        wb_en;
    word_t       stored1;
    word_t       stored2;
    logic [31:0] count_q;

    // Write-back mux; driven regardless of RegWrite so EX forwarding can see it.
    assign wb_sel = bus.control_MEM_WB[CTRL_MEMTOREG] ? bus.data_out_MEM_WB
                                                      : bus.alu_out_MEM_WB;

    // Writes to x0 are not writes at all: no commit, no count, no bypass.
    assign wb_en = bus.control_MEM_WB[CTRL_REGWRITE]
                 && (bus.Write_Reg_MEM_WB != REG_ZERO)
                 && !reset;

    assign bus.wb_data  = reset ? '0 : wb_sel;
    assign bus.wb_en    = wb_en;
    assign bus.wb_count = count_q;

    reg_array_2r1w #(.NREG(NREG)) u_array (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wb_en),
        .wr_addr  (bus.Write_Reg_MEM_WB),
        .wr_data  (wb_sel),
        .rd1_addr (bus.rs1_addr),
        .rd2_addr (bus.rs2_addr),
        .rd1_data (stored1),
        .rd2_data (stored2)
    );

    // Read ports: x0 and reset force 0, then same-cycle bypass, then storage.
    // NOTE: outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        if (!reset && bus.rs1_addr != REG_ZERO) begin
            if (BYPASS && wb_en && bus.rs1_addr == bus.Write_Reg_MEM_WB) bus.rs1_data = wb_sel;
            else                                                         bus.rs1_data = stored1;
        end
        if (!reset && bus.rs2_addr != REG_ZERO) begin
            if (BYPASS && wb_en && bus.rs2_addr == bus.Write_Reg_MEM_WB) bus.rs2_data = wb_sel;
            else                                                         bus.rs2_data = stored2;
        end
    end

    // Commit counter, wraps modulo 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      count_q <= '0;
        else if (wb_en) count_q <= count_q + 32'd1;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset clearing, write-back select, x0,
// bypass on/off, asynchronous mid-operation reset and counter wrap.
module tb_wb_regfile;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wb_regfile_if bus_a ();
    wb_regfile_if bus_b ();

    // The no-bypass instance sees exactly the same stimulus.
    assign bus_b.alu_out_MEM_WB   = bus_a.alu_out_MEM_WB;
    assign bus_b.data_out_MEM_WB  = bus_a.data_out_MEM_WB;
    assign bus_b.Write_Reg_MEM_WB = bus_a.Write_Reg_MEM_WB;
    assign bus_b.control_MEM_WB   = bus_a.control_MEM_WB;
    assign bus_b.rs1_addr         = bus_a.rs1_addr;
    assign bus_b.rs2_addr         = bus_a.rs2_addr;

    wb_regfile #(.NREG(32), .BYPASS(1'b1)) u_dut (.clk(clk), .reset(reset), .bus(bus_a));
    wb_regfile #(.NREG(32), .BYPASS(1'b0)) u_nobyp (.clk(clk), .reset(reset), .bus(bus_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ctrl, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] data,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        bus_a.control_MEM_WB   = ctrl;
        bus_a.Write_Reg_MEM_WB = rd;
        bus_a.alu_out_MEM_WB   = alu;
        bus_a.data_out_MEM_WB  = data;
        bus_a.rs1_addr         = ra1;
        bus_a.rs2_addr         = ra2;
    endtask

    initial begin
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);

        // Writes attempted under reset must all be discarded; bypass suppressed.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drive(2'b10, 5'(i), 32'h100 + 32'(i), 32'h0, 5'(i), 5'(i));
            #1;
            if (i == 31) begin
                check("rst_wb_en",   {31'd0, bus_a.wb_en}, 32'd0);
                check("rst_wb_data", bus_a.wb_data, 32'd0);
                check("rst_bypass",  bus_a.rs1_data, 32'd0);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        for (int i = 1; i < 32; i++) begin
            bus_a.rs1_addr = 5'(i);
            bus_a.rs2_addr = 5'(32 - i);
            #1;
            check($sformatf("rst_rs1_r%0d", i), bus_a.rs1_data, 32'd0);
            check($sformatf("rst_rs2_r%0d", 32 - i), bus_a.rs2_data, 32'd0);
        end
        check("rst_count", bus_a.wb_count, 32'd0);

        // Write-back select: ALU result, then load data, into x5.
        @(negedge clk);
        drive(2'b10, 5'd5, 32'h0000_1234, 32'hDEAD_BEEF, 5'd0, 5'd0);
        #1;
        check("sel_alu_wb_data", bus_a.wb_data, 32'h0000_1234);
        check("sel_alu_wb_en",   {31'd0, bus_a.wb_en}, 32'd1);
        @(negedge clk);
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0);
        #1;
        check("sel_alu_r5", bus_a.rs1_data, 32'h0000_1234);
        @(negedge clk);
        drive(2'b11, 5'd5, 32'h0000_1234, 32'hDEAD_BEEF, 5'd0, 5'd0);
        #1;
        check("sel_mem_wb_data", bus_a.wb_data, 32'hDEAD_BEEF);
        @(negedge clk);
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5);
        #1;
        check("sel_mem_r5", bus_a.rs2_data, 32'hDEAD_BEEF);
        check("sel_count",  bus_a.wb_count, 32'd2);

        // MemtoReg without RegWrite: wb_data still driven, nothing committed.
        @(negedge clk);
        drive(2'b01, 5'd5, 32'h1111_1111, 32'h2222_2222, 5'd5, 5'd0);
        #1;
        check("norw_wb_data", bus_a.wb_data, 32'h2222_2222);
        check("norw_wb_en",   {31'd0, bus_a.wb_en}, 32'd0);
        @(negedge clk);
        #1;
        check("norw_r5",    bus_a.rs1_data, 32'hDEAD_BEEF);
        check("norw_count", bus_a.wb_count, 32'd2);

        // x0: write is discarded and not counted.
        @(negedge clk);
        drive(2'b10, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0);
        #1;
        check("x0_wb_en", {31'd0, bus_a.wb_en}, 32'd0);
        check("x0_read",  bus_a.rs1_data, 32'd0);
        @(negedge clk);
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        #1;
        check("x0_read_after", bus_a.rs1_data, 32'd0);
        check("x0_count",      bus_a.wb_count, 32'd2);

        // Bypass on both ports in the same cycle; no-bypass instance sees old 0.
        @(negedge clk);
        drive(2'b10, 5'd7, 32'hA5A5_A5A5, 32'h0, 5'd7, 5'd7);
        #1;
        check("byp_rs1",   bus_a.rs1_data, 32'hA5A5_A5A5);
        check("byp_rs2",   bus_a.rs2_data, 32'hA5A5_A5A5);
        check("nobyp_rs1", bus_b.rs1_data, 32'd0);
        check("nobyp_rs2", bus_b.rs2_data, 32'd0);
        @(negedge clk);
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd7, 5'd5);
        #1;
        check("byp_r7_after",   bus_a.rs1_data, 32'hA5A5_A5A5);
        check("nobyp_r7_after", bus_b.rs1_data, 32'hA5A5_A5A5);
        check("byp_r5_other",   bus_a.rs2_data, 32'hDEAD_BEEF);
        check("byp_count",      bus_a.wb_count, 32'd3);

        // Asynchronous reset raised between edges while a write to x3 is pending.
        @(negedge clk);
        drive(2'b10, 5'd3, 32'h0000_0033, 32'h0, 5'd3, 5'd5);
        #1;
        check("mid_pre_bypass", bus_a.rs1_data, 32'h0000_0033);
        #1;
        reset = 1'b1;
        #1;
        check("mid_async_count", bus_a.wb_count, 32'd0);
        check("mid_async_r5",    bus_a.rs2_data, 32'd0);
        check("mid_async_wb_en", {31'd0, bus_a.wb_en}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd3, 5'd7);
        #1;
        check("mid_r3_dropped", bus_a.rs1_data, 32'd0);
        check("mid_r7_cleared", bus_a.rs2_data, 32'd0);
        check("mid_count",      bus_a.wb_count, 32'd0);
        @(negedge clk);
        drive(2'b10, 5'd3, 32'h0000_3333, 32'h0, 5'd3, 5'd0);
        @(negedge clk);
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd3, 5'd0);
        #1;
        check("mid_r3_commit", bus_a.rs1_data, 32'h0000_3333);
        check("mid_count_1",   bus_a.wb_count, 32'd1);

        // Counter wrap: preload all-ones, then a single commit.
        @(negedge clk);
        force u_dut.count_q = 32'hFFFF_FFFF;
        #1;
        release u_dut.count_q;
        #1;
        check("wrap_preload", bus_a.wb_count, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(2'b10, 5'd9, 32'h0000_0009, 32'h0, 5'd9, 5'd0);
        @(negedge clk);
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0);
        #1;
        check("wrap_zero", bus_a.wb_count, 32'd0);
        check("wrap_r9",   bus_a.rs1_data, 32'h0000_0009);
        @(negedge clk);
        drive(2'b11, 5'd9, 32'h0, 32'h0000_0099, 5'd9, 5'd0);
        @(negedge clk);
        drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0);
        #1;
        check("wrap_one", bus_a.wb_count, 32'd1);
        check("wrap_r9b", bus_a.rs1_data, 32'h0000_0099);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: the write-back stage plus the architectural integer register file.
- Selects the write-back value (load data or ALU result) from the MEM/WB fields and commits it to a 32-entry register file on the clock edge.
- Serves the decode stage's two asynchronous read ports, with same-cycle write-to-read bypass.
- Keeps a wrapping count of committed register writes for debug and performance monitoring.

Parameters:
- XLEN, 32, data width of registers and data paths.
- NREG, 32, number of architectural registers; index width is 5 bits (NREG fixed at 32).
- BYPASS, 1, 1 = read ports return write data when the read address matches the same-cycle write; 0 = read returns the old register contents.

Ports:
- clk  input  1  clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- alu_out_MEM_WB  input  XLEN  ALU result from the MEM/WB register.
- data_out_MEM_WB  input  XLEN  load data from the MEM/WB register.
- Write_Reg_MEM_WB  input  5  destination register index.
- control_MEM_WB  input  2  bit[1] = RegWrite, bit[0] = MemtoReg.
- rs1_addr  input  5  read port 1 index (from ID).
- rs2_addr  input  5  read port 2 index (from ID).
- rs1_data  output  XLEN  read port 1 data.
- rs2_data  output  XLEN  read port 2 data.
- wb_data  output  XLEN  selected write-back value, for forwarding to EX.
- wb_en  output  1  qualified write enable: RegWrite=1 and rd!=0.
- wb_count  output  32  number of committed writes, wrapping.

Behaviour:
- Reset (asynchronous, reset=1):
  - All NREG registers clear to 0 and wb_count clears to 0, immediately and without a clock edge.
  - While reset=1, rs1_data, rs2_data, wb_data and wb_en are all 0; bypass is suppressed.
- Write-back select (combinational): wb_data = MemtoReg ? data_out_MEM_WB : alu_out_MEM_WB. wb_data is driven even when RegWrite=0.
- wb_en = RegWrite & (Write_Reg_MEM_WB != 0) & ~reset.
- Commit: on a rising clk edge with wb_en=1, reg[Write_Reg_MEM_WB] <= wb_data. Write latency is 1 edge. Only one write per cycle.
- x0:
  - Always reads 0. A write with rd=0 is discarded.
  - A write with rd=0 does not update any register and does not increment wb_count.
- Reads (combinational, 0 latency):
  - rsN_data = 0 if rsN_addr=0.
  - Else, if BYPASS and wb_en and rsN_addr==Write_Reg_MEM_WB, rsN_data = wb_data.
  - Else rsN_data = reg[rsN_addr].
  - Both ports are independent; both may hit the bypass in the same cycle.
- Counter: on a rising edge with wb_en=1, wb_count <= wb_count + 1, modulo 2^32. 0xFFFFFFFF wraps to 0x00000000 with no flag.
- Reset mid-operation: a pending write in the same cycle that reset asserts is dropped. The register file and counter are 0 after reset deasserts.
- Reset release: the first edge after deassertion commits normally if wb_en=1.
- Inputs must be stable before the clock edge. There is no handshake and no stall input; the MEM/WB register upstream owns bubbles by setting control to 0.

Decomposition:
- Shared package pipe_pkg holds:
  - XLEN;
  - REG_IDX_W = 5;
  - the control bit positions CTRL_REGWRITE = 1 and CTRL_MEMTOREG = 0, so the MEM/WB register and this block share one encoding;
  - REG_ZERO = 5'd0.
- One natural sub-module: reg_array_2r1w, the NREG×XLEN storage with async reset, one synchronous write port and two async read ports.
- The top level keeps the write-back mux, bypass, x0 masking and counter.

Test Plan:
- Reset clears: assert reset, write all regs via the port, then deassert. rs1/rs2 read 0 for every index 1..31 and wb_count=0.
- Write-back select:
  - control=2'b10, alu=0x0000_1234, data=0xDEAD_BEEF, rd=5 → next cycle reg5 reads 0x0000_1234.
  - control=2'b11, same inputs → reg5 reads 0xDEAD_BEEF.
  - wb_count=2.
- x0 protection: control=2'b10, rd=0, alu=0xFFFF_FFFF → rs1_addr=0 reads 0, wb_en=0, wb_count unchanged.
- Bypass: in the same cycle, write rd=7 with value 0xA5A5_A5A5 and set rs1_addr=rs2_addr=7 → both outputs are 0xA5A5_A5A5 before the edge. With BYPASS=0 they return the old value 0.
- Mid-operation reset: raise reset asynchronously between edges while control=2'b10, rd=3 → reg3 stays 0 and wb_count=0 after release. The next write to rd=3 commits.
- Counter wrap: preload by 2^32−1 writes (or force the counter to 0xFFFF_FFFF in the bench), then do one write → wb_count=0x0000_0000.
